up_down_counter_mod: RTL

- Parametrised up/down counter for timers, pointers and event tallies.
- Generalises the fixed 8-bit up/down counter with:
  - configurable width and modulus;
  - variable step;
  - synchronous load and count enable;
  - run-time wrap/saturate mode;
  - terminal-count flags and registered wrap/saturate event pulses.
- Stand-alone leaf; drives control FSMs and status registers.

---
 rtl/up_down_counter_mod.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod: parametrised up/down counter with modulus, variable
// step, synchronous load, run-time wrap/saturate mode, terminal-count flags
// and registered wrap/saturate event pulses.
// Optional build macro UDC_PRESCALE_EN adds a count-enable prescaler of
// ratio PRESCALE; the port list is the same in both builds.
module up_down_counter_mod #(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 256,
    parameter int STEP_W   = 4,
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic              sat_mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              tc_max,
    output logic              tc_min,
    output logic              wrap_evt,
    output logic              sat_evt
);

    // All range arithmetic is one bit wider than the count so that
    // count + step and count + MODULO never overflow.
    localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULO - 1);

`ifdef UDC_PRESCALE_EN
    localparam bit PRESCALE_OK = (PRESCALE >= 2);
`else
    // Without the prescaler any PRESCALE value is accepted and ignored.
    localparam bit PRESCALE_OK = (PRESCALE >= 0) || (PRESCALE < 0);
`endif

    if (MODULO < 2 || MODULO > (1 << WIDTH) || (1 << STEP_W) > MODULO || !PRESCALE_OK)
    begin : g_param_check
        $error("up_down_counter_mod: illegal WIDTH/MODULO/STEP_W/PRESCALE combination");
    end

    // Clamp a widened value into 0..MODULO-1 (used for out-of-range loads).
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH:0] v);
        return (v > MAX_X) ? WIDTH'(MAX_X) : WIDTH'(v);
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             tick;

`ifdef UDC_PRESCALE_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    // Prescaler: advances on enabled non-load cycles, restarts on load.
    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = ps_q;
        if (load) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    logic [WIDTH:0]   cur_x, step_x, sum_x;
    logic [WIDTH-1:0] cnt_upd;
    logic             wrap_upd, sat_upd;

    // Candidate count for a counting cycle, with its wrap/saturate event.
    always_comb begin
        cur_x    = {1'b0, count_q};
        step_x   = (WIDTH+1)'(step);
        sum_x    = cur_x + step_x;
        cnt_upd  = count_q;
        wrap_upd = 1'b0;
        sat_upd  = 1'b0;
        if (up_down) begin
            if (sum_x <= MAX_X) begin
                cnt_upd = WIDTH'(sum_x);
            end else if (sat_mode) begin
                cnt_upd = WIDTH'(MAX_X);
                sat_upd = 1'b1;
            end else begin
                cnt_upd  = WIDTH'(sum_x - MOD_X);
                wrap_upd = 1'b1;
            end
        end else begin
            if (step_x <= cur_x) begin
                cnt_upd = WIDTH'(cur_x - step_x);
            end else if (sat_mode) begin
                cnt_upd = '0;
                sat_upd = 1'b1;
            end else begin
                cnt_upd  = WIDTH'(cur_x + MOD_X - step_x);
                wrap_upd = 1'b1;
            end
        end
    end

    // Next state: load beats counting; events only follow a counting update.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (load) begin
            count_d = clamp_to_max({1'b0, load_val});
        end else if (en && tick) begin
            count_d = cnt_upd;
            wrap_d  = wrap_upd;
            sat_d   = sat_upd;
        end
    end

    // Count and event registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign count    = count_q;
    assign tc_max   = ({1'b0, count_q} == MAX_X);
    assign tc_min   = (count_q == '0);
    assign wrap_evt = wrap_q;
    assign sat_evt  = sat_q;

endmodule
